// File: rtl/generic_fifo_sc_pf_if.sv
// Producer/consumer-side bundle for generic_fifo_sc_pf.
// The master side drives writes, reads, flush and thresholds; the FIFO is the slave.
interface generic_fifo_sc_pf_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          clr;
    logic [DW-1:0] din;
    logic          we;
    logic          re;
    logic [AW:0]   af_thr;
    logic [AW:0]   ae_thr;
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   cnt;
    logic          ovf;
    logic          udf;

    modport master (
        output clr, din, we, re, af_thr, ae_thr,
        input  dout, full, empty, almost_full, almost_empty, cnt, ovf, udf
    );

    modport slave (
        input  clr, din, we, re, af_thr, ae_thr,
        output dout, full, empty, almost_full, almost_empty, cnt, ovf, udf
    );
endinterface

// File: rtl/generic_fifo_sc_pf.sv
// Single-clock FIFO, DEPTH = 2**AW words of DW bits.
// Standard (registered, latency 1) or first-word-fall-through read mode,
// full-resolution occupancy, programmable almost-full/empty thresholds and
// sticky overflow/underflow flags. Requests that cannot be honoured are
// dropped without disturbing any other state.
module generic_fifo_sc_pf #(
    parameter int DW   = 8,
    parameter int AW   = 4,
    parameter int FWFT = 0
) (
    input  logic                  clk,
    input  logic                  rst,      // asynchronous, active low
    generic_fifo_sc_pf_if.slave   bus
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_CNT = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   cnt_reg;
    logic          ovf_reg;
    logic          udf_reg;

    logic          full;
    logic          empty;
    logic          wr_ok;
    logic          rd_ok;

    // Flags come straight from the registered count, so they settle one
    // cycle after the edge that moved it.
    assign full  = (cnt_reg == DEPTH_CNT);
    assign empty = (cnt_reg == '0);

    // Accept decisions use pre-edge state; a flush swallows both requests.
    assign wr_ok = bus.we & ~full  & ~bus.clr;
    assign rd_ok = bus.re & ~empty & ~bus.clr;

    // Storage array: no reset, written only on an accepted write.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr_reg] <= bus.din;
    end

    // Pointers and occupancy; both pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else if (bus.clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (wr_ok)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (rd_ok)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   cnt_reg <= cnt_reg + (AW+1)'(1);
                2'b01:   cnt_reg <= cnt_reg - (AW+1)'(1);
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

    // Sticky error flags: any ungated request against a full/empty FIFO
    // latches until flush or reset. A flush cycle never sets them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_reg <= 1'b0;
            udf_reg <= 1'b0;
        end else if (bus.clr) begin
            ovf_reg <= 1'b0;
            udf_reg <= 1'b0;
        end else begin
            ovf_reg <= ovf_reg | (bus.we & full);
            udf_reg <= udf_reg | (bus.re & empty);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always visible while data is present; the array
            // is read asynchronously so a fresh write shows one clock later.
            assign bus.dout = empty ? '0 : mem[rd_ptr_reg];
        end else begin : g_std
            logic [DW-1:0] dout_reg;

            // Registered read: load on an accepted read, hold otherwise.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    dout_reg <= '0;
                else if (bus.clr)
                    dout_reg <= '0;
                else if (rd_ok)
                    dout_reg <= mem[rd_ptr_reg];
            end

            assign bus.dout = dout_reg;
        end
    endgenerate

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (cnt_reg >= bus.af_thr);
    assign bus.almost_empty = (cnt_reg <= bus.ae_thr);
    assign bus.cnt          = cnt_reg;
    assign bus.ovf          = ovf_reg;
    assign bus.udf          = udf_reg;

endmodule

// File: tb/tb_generic_fifo_sc_pf.sv
// Bench for generic_fifo_sc_pf: a standard-mode and an FWFT-mode instance
// receive identical stimulus and are checked against one queue-based model.
module tb_generic_fifo_sc_pf;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          we  = 1'b0;
    logic          re  = 1'b0;
    logic [DW-1:0] din = '0;
    logic [AW:0]   af_thr = 5'd12;
    logic [AW:0]   ae_thr = 5'd3;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;
    logic [DW-1:0] m_dout_std = '0;

    always #5 clk = ~clk;

    generic_fifo_sc_pf_if #(.DW(DW), .AW(AW)) if_std ();
    generic_fifo_sc_pf_if #(.DW(DW), .AW(AW)) if_fw ();

    assign if_std.clr = clr;    assign if_fw.clr = clr;
    assign if_std.din = din;    assign if_fw.din = din;
    assign if_std.we  = we;     assign if_fw.we  = we;
    assign if_std.re  = re;     assign if_fw.re  = re;
    assign if_std.af_thr = af_thr;  assign if_fw.af_thr = af_thr;
    assign if_std.ae_thr = ae_thr;  assign if_fw.ae_thr = ae_thr;

    generic_fifo_sc_pf #(.DW(DW), .AW(AW), .FWFT(0)) u_std (
        .clk (clk),
        .rst (rst),
        .bus (if_std.slave)
    );

    generic_fifo_sc_pf #(.DW(DW), .AW(AW), .FWFT(1)) u_fw (
        .clk (clk),
        .rst (rst),
        .bus (if_fw.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output of both instances with the model.
    task automatic check_all(input string tag);
        int sz;
        logic [DW-1:0] head;
        sz   = q.size();
        head = (sz > 0) ? q[0] : '0;
        chk({tag, " cnt"},   32'(if_std.cnt), 32'(sz));
        chk({tag, " cntF"},  32'(if_fw.cnt),  32'(sz));
        chk({tag, " full"},  32'(if_std.full),  32'(sz == DEPTH));
        chk({tag, " fullF"}, 32'(if_fw.full),   32'(sz == DEPTH));
        chk({tag, " empty"}, 32'(if_std.empty), 32'(sz == 0));
        chk({tag, " emptyF"},32'(if_fw.empty),  32'(sz == 0));
        chk({tag, " af"},    32'(if_std.almost_full),  32'(sz >= int'(af_thr)));
        chk({tag, " afF"},   32'(if_fw.almost_full),   32'(sz >= int'(af_thr)));
        chk({tag, " ae"},    32'(if_std.almost_empty), 32'(sz <= int'(ae_thr)));
        chk({tag, " aeF"},   32'(if_fw.almost_empty),  32'(sz <= int'(ae_thr)));
        chk({tag, " ovf"},   32'(if_std.ovf), 32'(m_ovf));
        chk({tag, " ovfF"},  32'(if_fw.ovf),  32'(m_ovf));
        chk({tag, " udf"},   32'(if_std.udf), 32'(m_udf));
        chk({tag, " udfF"},  32'(if_fw.udf),  32'(m_udf));
        chk({tag, " dout"},  32'(if_std.dout), 32'(m_dout_std));
        chk({tag, " doutF"}, 32'(if_fw.dout),  32'(head));
    endtask

    // Model of one rising edge, from the request rules alone.
    task automatic model_edge(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
        bit was_full, was_empty;
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_dout_std = '0;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            if (w && was_full)  m_ovf = 1'b1;
            if (r && was_empty) m_udf = 1'b1;
            if (r && !was_empty) m_dout_std = q.pop_front();
            if (w && !was_full)  q.push_back(d);
        end
    endtask

    // One clock: drive after the falling edge, check at the next falling edge.
    task automatic tick(input string tag, input logic w, input logic r,
                        input logic [DW-1:0] d, input logic c);
        we = w; re = r; din = d; clr = c;
        @(posedge clk);
        model_edge(w, r, d, c);
        @(negedge clk);
        $display("%0t %s we=%b re=%b clr=%b din=%h cnt=%0d dout=%h/%h", $time, tag,
                 w, r, c, d, if_std.cnt, if_std.dout, if_fw.dout);
        check_all(tag);
    endtask

    initial begin
        // 1. Reset and initial flags
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all("in_reset");
        rst = 1'b1;
        @(negedge clk);
        check_all("reset");

        // 2. Fill, overflow, drain, wrap
        for (int i = 0; i < DEPTH; i++) tick("fill", 1, 0, 8'($urandom), 0);
        tick("ovf", 1, 0, 8'hAA, 0);
        for (int i = 0; i < DEPTH; i++) tick("drain", 0, 1, 8'h00, 0);
        for (int i = 0; i < 40; i++) begin
            tick("wrap_w", 1, 0, 8'($urandom), 0);
            tick("wrap_r", 0, 1, 8'h00, 0);
        end

        // 3. Threshold crossings both ways
        tick("clr", 0, 0, 8'h00, 1);
        af_thr = 5'd12; ae_thr = 5'd3;
        for (int i = 0; i < DEPTH; i++) tick("thr_up", 1, 0, 8'($urandom), 0);
        for (int i = 0; i < DEPTH; i++) tick("thr_dn", 0, 1, 8'h00, 0);

        // 4. Simultaneous read and write
        for (int i = 0; i < 5; i++) tick("pre5", 1, 0, 8'($urandom), 0);
        for (int i = 0; i < 10; i++) tick("rw5", 1, 1, 8'($urandom), 0);
        for (int i = 0; i < 5; i++) tick("dr5", 0, 1, 8'h00, 0);
        tick("rw_empty", 1, 1, 8'h77, 0);
        for (int i = 0; i < DEPTH - 1; i++) tick("fill2", 1, 0, 8'($urandom), 0);
        tick("rw_full", 1, 1, 8'h99, 0);

        // 5. Fall-through of a single word
        tick("clr", 0, 0, 8'h00, 1);
        tick("fw_w", 1, 0, 8'h3C, 0);
        tick("fw_hold", 0, 0, 8'h00, 0);
        tick("fw_r", 0, 1, 8'h00, 0);

        // 6. Flush with a concurrent write, then reset mid-burst
        for (int i = 0; i < 7; i++) tick("pre7", 1, 0, 8'($urandom), 0);
        tick("clr_we", 1, 0, 8'h55, 1);
        tick("after_clr", 0, 1, 8'h00, 0);
        for (int i = 0; i < 5; i++) tick("burst", 1, 0, 8'($urandom), 0);
        we = 1'b1; re = 1'b0; din = 8'hE1;
        #2 rst = 1'b0;
        #1;
        q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_dout_std = '0;
        check_all("async_rst");
        we = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) tick("post_w", 1, 0, 8'($urandom), 0);
        for (int i = 0; i < 4; i++) tick("post_r", 0, 1, 8'h00, 0);

        // 7. Random traffic with live threshold changes and occasional flush
        for (int i = 0; i < 400; i++) begin
            if (i % 25 == 0) begin
                af_thr = 5'($urandom_range(0, DEPTH));
                ae_thr = 5'($urandom_range(0, DEPTH));
            end
            tick("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom), 1'($urandom_range(0, 39) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/generic_fifo_sc_pf.md
Name: generic_fifo_sc_pf

Overview:
- Parametrised single-clock synchronous FIFO. Successor to the existing single-clock FIFO.
- Generalises data width and depth (power of two).
- Adds selectable first-word-fall-through (FWFT) read mode, full-resolution occupancy count, runtime-programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags.
- Sits between a producer and a consumer in the same clock domain.
- Callers may gate we/re with full/empty as today; the block also protects itself against ungated requests.

Parameters:
- DW, 8, data width in bits.
- AW, 4, address width; depth DEPTH = 2^AW entries.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear (flush), active high.
- din  in  DW  write data.
- we  in  1  write request.
- re  in  1  read request.
- af_thr  in  AW+1  almost-full threshold, 0..DEPTH.
- ae_thr  in  AW+1  almost-empty threshold, 0..DEPTH.
- dout  out  DW  read data.
- full  out  1  cnt == DEPTH.
- empty  out  1  cnt == 0.
- almost_full  out  1  cnt >= af_thr.
- almost_empty  out  1  cnt <= ae_thr.
- cnt  out  AW+1  current occupancy, 0..DEPTH.
- ovf  out  1  sticky: write requested while full.
- udf  out  1  sticky: read requested while empty.

Behaviour:
- Storage: DEPTH x DW array, no reset on contents.
  - wr_ptr and rd_ptr are AW bits and wrap modulo DEPTH.
  - cnt is a separate AW+1-bit register.
- Accept rules:
  - wr_ok = we & !full.
  - rd_ok = re & !empty.
  - Both are evaluated on pre-edge state.
  - A write when full is never accepted, even with a same-cycle read.
  - A read when empty is never accepted, even with a same-cycle write.
- Edge update:
  - wr_ok stores din at wr_ptr and increments wr_ptr.
  - rd_ok increments rd_ptr.
  - cnt changes by +1 (wr_ok only), -1 (rd_ok only), or 0 (both or neither).
- Flags:
  - full, empty, almost_full and almost_empty are combinational from registered cnt and the live threshold inputs.
  - They are therefore valid the cycle after the edge that changed cnt.
- Errors:
  - ovf is set on an edge where we & full; udf is set on an edge where re & empty.
  - Both hold until clr or rst.
  - A rejected request changes no other state.
- Standard mode (FWFT=0):
  - On rd_ok, dout is loaded from mem[rd_ptr] at that edge (read latency 1 clock).
  - dout holds its value on all other cycles, including after the FIFO goes empty.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr] whenever !empty; dout = 0 when empty.
  - A write into an empty FIFO appears on dout after that write edge (1 clock).
  - rd_ok consumes the displayed word; the next word, if any, appears after the edge.
- clr:
  - At the edge: pointers, cnt, ovf and udf go to 0; standard-mode dout goes to 0.
  - clr has priority over same-cycle we/re; those requests are dropped and set no error flags.
- Reset (rst low, asynchronous):
  - Pointers, cnt, ovf, udf and dout registers go to 0.
  - Resulting outputs: empty=1, full=0, cnt=0, almost_empty=1, almost_full=(af_thr==0), dout=0.
  - Reset asserted mid-transfer discards all content; the first read after release returns the first word written after release.
- Thresholds:
  - May change at any time; the effect is combinational.
  - af_thr=0 forces almost_full=1.
  - ae_thr>=DEPTH forces almost_empty=1.

Test Plan (DW=8, AW=4, DEPTH=16):
1. Reset/flags: hold rst low, then release with af_thr=12, ae_thr=3 -> empty=1, full=0, cnt=0, almost_empty=1, almost_full=0, dout=00, ovf=udf=0.
2. Fill/wrap, FWFT=0: write 16 random bytes -> full=1 and cnt=16. Then:
   - Write 17th byte AA -> rejected, ovf=1, cnt=16.
   - Read 16 -> data in order, each on dout 1 clock after its read edge.
   - Write/read 40 more -> pointers wrap, no mismatch, empty=1 at end.
3. Threshold crossing: af_thr=12, ae_thr=3. Write one per clock -> almost_empty drops when cnt=4 and almost_full rises when cnt=12. Read back -> symmetric transitions at cnt=11 and cnt=3.
4. Simultaneous ops:
   - cnt=5, we=re=1 for 10 clocks -> cnt stays 5, in-order data.
   - Empty with we=re=1 -> write accepted, udf=1, cnt=1.
   - Full with we=re=1 -> read accepted, ovf=1, cnt=15.
5. FWFT=1: write 3C into empty -> dout=3C and empty=0 after that edge, with no re. Then re=1 for one clock -> dout=0, empty=1.
6. clr and mid-op reset:
   - cnt=7, pulse clr together with we=1, din=55 -> cnt=0, ovf=udf=0, 55 not stored.
   - Separately, assert rst during a burst -> immediate empty=1, cnt=0; post-release data matches only post-release writes.
